core_mem_scheduler: RTL and testbench

- Sits between the three core memory requesters (fetch, LSU, debug) and one shared single-port memory interface.
- Arbitrates per cycle with LSU > fetch > debug priority, plus a starvation override for fetch.
- Tracks in-flight reads in a tag FIFO and routes each read response to the requester that issued it.
- Handles fetch flush by draining and discarding outstanding fetch reads.

---
 rtl/core_mem_pkg.sv | 9 +
 rtl/core_mem_tag_fifo.sv | 50 +++++
 rtl/core_mem_scheduler.sv | 149 ++++++++++++++
 tb/tb_core_mem_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_pkg.sv
// core_mem_pkg: shared types for the core memory scheduler and its tag FIFO.
package core_mem_pkg;
    typedef enum logic [1:0] {MP_LSU = 2'd0, MP_FETCH = 2'd1, MP_DEBUG = 2'd2} mem_port_e;
    typedef struct packed {
        mem_port_e port;
        logic      discard;
    } mem_tag_t;
    typedef enum logic {S_RUN = 1'b0, S_DRAIN = 1'b1} sched_state_e;
endpackage

// File: rtl/core_mem_tag_fifo.sv
// core_mem_tag_fifo: in-order tag FIFO for outstanding reads; tracks fetch tags
// and can mark every queued fetch tag for discard.
module core_mem_tag_fifo
    import core_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  mem_tag_t                     i_tag,
    input  logic                         i_pop,
    input  logic                         i_mark_fetch_discard,
    output mem_tag_t                     o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_fetch_inflight
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    mem_tag_t      mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, inflight_q;
    logic          do_push, do_pop;
    assign o_full           = cnt_q == CW'(DEPTH);
    assign o_empty          = cnt_q == '0;
    assign o_head           = mem_q[rd_q];
    assign o_fetch_inflight = inflight_q;
    assign do_push          = i_push & ~o_full;
    assign do_pop           = i_pop & ~o_empty;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            inflight_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            // stale slots may get marked too; they are overwritten on push
            for (int i = 0; i < DEPTH; i++)
                if (i_mark_fetch_discard && mem_q[i].port == MP_FETCH) mem_q[i].discard <= 1'b1;
            if (do_push) mem_q[wr_q] <= i_tag;
            wr_q       <= wr_q + PW'(do_push);
            rd_q       <= rd_q + PW'(do_pop);
            cnt_q      <= cnt_q + CW'(do_push) - CW'(do_pop);
            inflight_q <= inflight_q + CW'(do_push && i_tag.port == MP_FETCH)
                                     - CW'(do_pop && o_head.port == MP_FETCH);
        end
    end
endmodule

// File: rtl/core_mem_scheduler.sv
// core_mem_scheduler: LSU > fetch > debug arbiter onto one memory port with fetch
// starvation override, in-order response routing and fetch flush drain.
// Define CORE_MEM_SCHED_PERF_EN to add grant and stall performance counters.
module core_mem_scheduler
    import core_mem_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TAG_DEPTH  = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clk_en,
    input  logic          i_fetch_flush,
    input  logic          i_fetch_req,
    input  logic [AW-1:0] i_fetch_addr,
    output logic          o_fetch_gnt,
    output logic          o_fetch_rvalid,
    output logic [DW-1:0] o_fetch_rdata,
    input  logic          i_lsu_req,
    input  logic          i_lsu_we,
    input  logic [AW-1:0] i_lsu_addr,
    input  logic [3:0]    i_lsu_be,
    input  logic [DW-1:0] i_lsu_wdata,
    output logic          o_lsu_gnt,
    output logic          o_lsu_rvalid,
    output logic [DW-1:0] o_lsu_rdata,
    input  logic          i_debug_req,
    input  logic          i_debug_we,
    input  logic [AW-1:0] i_debug_addr,
    input  logic [3:0]    i_debug_be,
    input  logic [DW-1:0] i_debug_wdata,
    output logic          o_debug_gnt,
    output logic          o_debug_rvalid,
    output logic [DW-1:0] o_debug_rdata,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [3:0]    o_mem_be,
    output logic [DW-1:0] o_mem_wdata,
    input  logic          i_mem_rvalid,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_stall,
    output logic          o_err
`ifdef CORE_MEM_SCHED_PERF_EN
   ,output logic [31:0]   o_perf_grants,
    output logic [31:0]   o_perf_stall
`endif
);
    localparam int CW = $clog2(TAG_DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    sched_state_e  state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    mem_tag_t      head, push_tag;
    logic [CW-1:0] fetch_inflight;
    logic          full, empty, go, lsu_ok, dbg_ok, fetch_ok, force_fetch;
    logic          any_gnt, push, pop, pop_fetch, mark;
    logic          mem_req_q, mem_we_q, lsu_rv_q, fetch_rv_q, dbg_rv_q, err_q;
    logic [AW-1:0] mem_addr_q;
    logic [3:0]    mem_be_q;
    logic [DW-1:0] mem_wdata_q, rdata_q;
    // grants are held off while in reset so every output reads 0
    assign go          = i_clk_en & i_rst_n;
    assign lsu_ok      = i_lsu_req & (i_lsu_we | ~full);
    assign dbg_ok      = i_debug_req & (i_debug_we | ~full);
    assign fetch_ok    = i_fetch_req & ~full & (state_q == S_RUN) & ~i_fetch_flush;
    assign force_fetch = fetch_ok & (starve_q == SW'(STARVE_MAX));
    assign o_lsu_gnt   = go & lsu_ok & ~force_fetch;
    assign o_fetch_gnt = go & fetch_ok & (force_fetch | ~lsu_ok);
    assign o_debug_gnt = go & dbg_ok & ~lsu_ok & ~fetch_ok;
    assign any_gnt     = o_lsu_gnt | o_fetch_gnt | o_debug_gnt;
    assign o_stall     = i_rst_n & (i_lsu_req | i_fetch_req | i_debug_req) & ~any_gnt;
    assign push        = o_fetch_gnt | (o_lsu_gnt & ~i_lsu_we) | (o_debug_gnt & ~i_debug_we);
    assign push_tag    = '{port: o_fetch_gnt ? MP_FETCH : o_lsu_gnt ? MP_LSU : MP_DEBUG, discard: 1'b0};
    assign pop         = go & i_mem_rvalid & ~empty;
    assign pop_fetch   = pop & (head.port == MP_FETCH);
    assign mark        = go & i_fetch_flush;
    core_mem_tag_fifo #(.DEPTH(TAG_DEPTH)) u_fifo (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_push(push), .i_tag(push_tag), .i_pop(pop),
        .i_mark_fetch_discard(mark), .o_head(head), .o_full(full), .o_empty(empty),
        .o_fetch_inflight(fetch_inflight)
    );
    always_comb begin
        starve_d = starve_q;
        state_d  = state_q;
        if (go) begin
            starve_d = (i_fetch_req && !o_fetch_gnt)
                     ? ((starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1)) : '0;
            if (state_q == S_RUN) state_d = (i_fetch_flush && fetch_inflight != '0) ? S_DRAIN : S_RUN;
            else                  state_d = (fetch_inflight == CW'(pop_fetch)) ? S_RUN : S_DRAIN;
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_RUN;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            lsu_rv_q    <= 1'b0;
            fetch_rv_q  <= 1'b0;
            dbg_rv_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else if (i_clk_en) begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= any_gnt;
            mem_we_q    <= o_lsu_gnt ? i_lsu_we : (o_debug_gnt & i_debug_we);
            mem_addr_q  <= o_lsu_gnt ? i_lsu_addr : o_fetch_gnt ? i_fetch_addr : o_debug_gnt ? i_debug_addr : '0;
            mem_be_q    <= o_lsu_gnt ? i_lsu_be : o_fetch_gnt ? 4'hF : o_debug_gnt ? i_debug_be : 4'h0;
            mem_wdata_q <= o_lsu_gnt ? i_lsu_wdata : o_debug_gnt ? i_debug_wdata : '0;
            lsu_rv_q    <= pop & ~head.discard & (head.port == MP_LSU);
            fetch_rv_q  <= pop & ~head.discard & (head.port == MP_FETCH);
            dbg_rv_q    <= pop & ~head.discard & (head.port == MP_DEBUG);
            rdata_q     <= (pop & ~head.discard) ? i_mem_rdata : rdata_q;
            err_q       <= err_q | (i_mem_rvalid & empty);
        end
    end
    assign o_mem_req      = mem_req_q;
    assign o_mem_we       = mem_we_q;
    assign o_mem_addr     = mem_addr_q;
    assign o_mem_be       = mem_be_q;
    assign o_mem_wdata    = mem_wdata_q;
    assign o_lsu_rvalid   = lsu_rv_q;
    assign o_fetch_rvalid = fetch_rv_q;
    assign o_debug_rvalid = dbg_rv_q;
    assign o_lsu_rdata    = rdata_q;
    assign o_fetch_rdata  = rdata_q;
    assign o_debug_rdata  = rdata_q;
    assign o_err          = err_q;
`ifdef CORE_MEM_SCHED_PERF_EN
    logic [31:0] perf_grants_q, perf_stall_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            perf_grants_q <= '0;
            perf_stall_q  <= '0;
        end else if (i_clk_en) begin
            perf_grants_q <= perf_grants_q + 32'(any_gnt);
            perf_stall_q  <= perf_stall_q + 32'(o_stall);
        end
    end
    assign o_perf_grants = perf_grants_q;
    assign o_perf_stall  = perf_stall_q;
`endif
endmodule

// File: tb/tb_core_mem_scheduler.sv
// tb_core_mem_scheduler: grant-table vectors, response scoreboard fed by a small
// memory model, and hand sequences for starvation, full FIFO, flush, error, reset.
module tb_core_mem_scheduler;
    logic        clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1, flush = 1'b0;
    logic        fetch_req = 1'b0, lsu_req = 1'b0, lsu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] fetch_addr = '0, lsu_addr = '0, lsu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
    logic [3:0]  lsu_be = 4'hF, dbg_be = 4'hF;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        o_fetch_gnt, o_fetch_rvalid, o_lsu_gnt, o_lsu_rvalid, o_debug_gnt, o_debug_rvalid;
    logic [31:0] o_fetch_rdata, o_lsu_rdata, o_debug_rdata, o_mem_addr, o_mem_wdata;
    logic        o_mem_req, o_mem_we, o_stall, o_err;
    logic [3:0]  o_mem_be;
`ifdef CORE_MEM_SCHED_PERF_EN
    logic [31:0] o_perf_grants, o_perf_stall;
`endif
    typedef struct {int port; logic [31:0] data;} exp_t;
    typedef struct {logic en, lr, lw, fr, dr, dw, el, ef, ed, es;} vec_t;
    exp_t        exp_q[$];
    logic [31:0] pend_q[$];
    int          checks = 0, errors = 0, credit_given = 0, credit_used = 0;
    bit          auto_rsp = 1'b1, force_rv = 1'b0;
    vec_t        v[10];

    core_mem_scheduler dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_fetch_flush(flush),
        .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr), .o_fetch_gnt(o_fetch_gnt),
        .o_fetch_rvalid(o_fetch_rvalid), .o_fetch_rdata(o_fetch_rdata),
        .i_lsu_req(lsu_req), .i_lsu_we(lsu_we), .i_lsu_addr(lsu_addr), .i_lsu_be(lsu_be),
        .i_lsu_wdata(lsu_wdata), .o_lsu_gnt(o_lsu_gnt), .o_lsu_rvalid(o_lsu_rvalid),
        .o_lsu_rdata(o_lsu_rdata), .i_debug_req(dbg_req), .i_debug_we(dbg_we),
        .i_debug_addr(dbg_addr), .i_debug_be(dbg_be), .i_debug_wdata(dbg_wdata),
        .o_debug_gnt(o_debug_gnt), .o_debug_rvalid(o_debug_rvalid), .o_debug_rdata(o_debug_rdata),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be),
        .o_mem_wdata(o_mem_wdata), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
        .o_stall(o_stall), .o_err(o_err)
`ifdef CORE_MEM_SCHED_PERF_EN
       ,.o_perf_grants(o_perf_grants), .o_perf_stall(o_perf_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a == 32'h200) ? 32'hA : (a == 32'h0) ? 32'hB : a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic idle();
        clk_en = 1'b1; flush = 1'b0;
        fetch_req = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // memory model: in-order reads, answered automatically or per granted credit
    always @(negedge clk) begin
        #1;
        if (o_mem_req && !o_mem_we) pend_q.push_back(o_mem_addr);
        if (force_rv) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
        end else if (pend_q.size() > 0 && (auto_rsp || credit_given > credit_used)) begin
            mem_rvalid = 1'b1; mem_rdata = mdata(pend_q.pop_front());
            if (!auto_rsp) credit_used++;
        end else begin
            mem_rvalid = 1'b0; mem_rdata = '0;
        end
    end

    // scoreboard: check responses on the negedge, record new read grants after inputs settle
    always @(negedge clk) begin : scoreboard
        int n, p;
        logic [31:0] d;
        exp_t e;
        n = int'(o_lsu_rvalid) + int'(o_fetch_rvalid) + int'(o_debug_rvalid);
        if (n > 1) chk("rvalid_onehot", n, 1);
        else if (n == 1) begin
            p = o_lsu_rvalid ? 0 : o_fetch_rvalid ? 1 : 2;
            d = o_lsu_rvalid ? o_lsu_rdata : o_fetch_rvalid ? o_fetch_rdata : o_debug_rdata;
            if (exp_q.size() == 0) chk("rsp_unexpected_port", p, 99);
            else begin
                e = exp_q.pop_front();
                chk("rsp_port", p, e.port);
                chk("rsp_data", d, e.data);
            end
        end
        #2;
        if (!rst_n) exp_q.delete();
        else if (clk_en) begin
            if (flush)
                for (int i = exp_q.size() - 1; i >= 0; i--)
                    if (exp_q[i].port == 1) exp_q.delete(i);
            if (o_lsu_gnt && !lsu_we) exp_q.push_back('{0, mdata(lsu_addr)});
            if (o_fetch_gnt) exp_q.push_back('{1, mdata(fetch_addr)});
            if (o_debug_gnt && !dbg_we) exp_q.push_back('{2, mdata(dbg_addr)});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        v[0] = '{1,1,0,0,0,0, 1,0,0,0};
        v[1] = '{1,0,0,1,0,0, 0,1,0,0};
        v[2] = '{1,0,0,0,1,0, 0,0,1,0};
        v[3] = '{1,1,0,1,0,0, 1,0,0,0};
        v[4] = '{1,0,0,1,1,0, 0,1,0,0};
        v[5] = '{1,1,0,0,1,0, 1,0,0,0};
        v[6] = '{1,1,0,1,1,0, 1,0,0,0};
        v[7] = '{1,0,0,0,0,0, 0,0,0,0};
        v[8] = '{0,1,0,1,0,0, 0,0,0,1};
        v[9] = '{1,1,1,0,1,1, 1,0,0,0};
        #3;
        chk("reset_outs", {o_mem_req, o_err, o_stall, o_lsu_rvalid, o_fetch_rvalid, o_debug_rvalid}, '0);
        chk("reset_mem_addr", o_mem_addr, '0);
        @(negedge clk) rst_n = 1'b1;
        cyc(2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            clk_en = v[i].en; lsu_req = v[i].lr; lsu_we = v[i].lw; fetch_req = v[i].fr;
            dbg_req = v[i].dr; dbg_we = v[i].dw;
            lsu_addr = 32'h500 + 32'(i * 16); fetch_addr = 32'h600 + 32'(i * 16); dbg_addr = 32'h700 + 32'(i * 16);
            #1;
            chk($sformatf("vec%0d_gnt", i), {o_lsu_gnt, o_fetch_gnt, o_debug_gnt}, {v[i].el, v[i].ef, v[i].ed});
            chk($sformatf("vec%0d_stall", i), o_stall, v[i].es);
            @(negedge clk) idle();
            cyc(3);
        end
        // LSU and fetch together: LSU first, then fetch, responses routed in order
        auto_rsp = 1'b0;
        @(negedge clk);
        lsu_req = 1'b1; lsu_addr = 32'h200; fetch_req = 1'b1; fetch_addr = 32'h0;
        #1 chk("t1_gnt0", {o_lsu_gnt, o_fetch_gnt}, 2'b10);
        @(negedge clk);
        chk("t1_cmd0", {o_mem_req, o_mem_we}, 2'b10);
        chk("t1_addr0", o_mem_addr, 32'h200);
        lsu_req = 1'b0;
        #1 chk("t1_gnt1", {o_lsu_gnt, o_fetch_gnt}, 2'b01);
        @(negedge clk);
        chk("t1_addr1", o_mem_addr, 32'h0);
        fetch_req = 1'b0;
        credit_given += 2;
        @(negedge clk) chk("t1_rv_lsu", {o_lsu_rvalid, o_fetch_rvalid}, 2'b10);
        @(negedge clk) chk("t1_rv_fetch", {o_lsu_rvalid, o_fetch_rvalid}, 2'b01);
        cyc(3);
        // starvation: fetch forced ahead of LSU on the 9th cycle only
        auto_rsp = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lsu_req = 1'b1; lsu_addr = 32'h1000 + 32'(i * 4); fetch_req = 1'b1; fetch_addr = 32'h80;
            #1 chk($sformatf("starve_c%0d", i), {o_lsu_gnt, o_fetch_gnt}, (i == 8) ? 2'b01 : 2'b10);
        end
        @(negedge clk) idle();
        cyc(5);
        // four fetch reads fill the tag FIFO; a write still gets through
        auto_rsp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            fetch_req = 1'b1; fetch_addr = 32'h40 + 32'(i * 4);
            if (i == 5) begin lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h900; end
            #1;
            if (i < 4) chk($sformatf("full_fgnt%0d", i), o_fetch_gnt, 1'b1);
            else if (i == 4) chk("full_stall", {o_fetch_gnt, o_stall}, 2'b01);
            else chk("full_write", {o_lsu_gnt, o_fetch_gnt}, 2'b10);
        end
        @(negedge clk) idle();
        credit_given += 4;
        cyc(8);
        // flush with three fetch reads in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            fetch_req = 1'b1; fetch_addr = 32'hC0 + 32'(i * 4);
            #1 chk($sformatf("fl_fgnt%0d", i), o_fetch_gnt, 1'b1);
        end
        @(negedge clk);
        fetch_req = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; fetch_req = 1'b1; fetch_addr = 32'hF0; dbg_req = 1'b1; dbg_addr = 32'h300;
        #1 chk("fl_drain_dbg", {o_fetch_gnt, o_debug_gnt}, 2'b01);
        @(negedge clk);
        dbg_req = 1'b0;
        credit_given += 4;
        #1 chk("fl_drain_n5", o_fetch_gnt, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("fl_no_rv%0d", i), o_fetch_rvalid, 1'b0);
            #1 chk($sformatf("fl_fgnt_after%0d", i), o_fetch_gnt, (i == 2) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        chk("fl_dbg_rv", o_debug_rvalid, 1'b1);
        fetch_req = 1'b0; auto_rsp = 1'b1;
        cyc(5);
        // response with nothing outstanding sets the sticky error
        chk("err_before", o_err, 1'b0);
        force_rv = 1'b1;
        @(negedge clk) force_rv = 1'b0;
        @(negedge clk) chk("err_set", o_err, 1'b1);
        cyc(3);
        chk("err_sticky", o_err, 1'b1);
        // reset with two reads in flight
        auto_rsp = 1'b0;
        @(negedge clk);
        lsu_req = 1'b1; lsu_addr = 32'h900;
        #1 chk("rst_lgnt", o_lsu_gnt, 1'b1);
        @(negedge clk);
        lsu_req = 1'b0; dbg_req = 1'b1; dbg_addr = 32'hA00;
        #1 chk("rst_dgnt", o_debug_gnt, 1'b1);
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        #1;
        chk("rst_outs", {o_mem_req, o_err, o_stall, o_lsu_rvalid, o_fetch_rvalid, o_debug_rvalid}, '0);
        chk("rst_addr", o_mem_addr, '0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) chk("rst_err_clear", o_err, 1'b0);
        credit_given = credit_used + 1;
        @(negedge clk) chk("rst_late_rsp_err", o_err, 1'b1);
        auto_rsp = 1'b1;
        cyc(4);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
